pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage of the core. It produces the fetch PC with a valid/ready handshake toward instruction fetch and holds the PC under backpressure. Redirects from trap logic and from the execute stage are prioritised. A small direct-mapped branch target buffer (BTB) predicts taken-branch targets. It sits between reset and IF, and is fed back from EX and the trap unit.

---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_btb.sv | 62 ++++++
 rtl/pc_gen.sv | 92 +++++++++
 tb/tb_pc_gen.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: default reset vector,
// instruction size and the next-PC source selector.
package pc_gen_pkg;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;
   localparam int          INST_BYTES           = 4;

   typedef enum logic [1:0] {
      TRAP = 2'd0,
      EX   = 2'd1,
      PRED = 2'd2,
      HOLD = 2'd3
   } pc_next_sel_e;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC and
// registered update from resolved control-flow instructions in EX.
module pc_btb #(
   parameter int XLEN        = 32,
   parameter int BTB_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            hit,
   output logic [XLEN-1:0] target,
   input  logic            update_valid,
   input  logic [XLEN-1:0] update_pc,
   input  logic            update_taken,
   input  logic [XLEN-1:0] update_target
);

   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX - 2;

   logic [BTB_ENTRIES-1:0] valid;
   logic [TAG_W-1:0]       tag_mem    [BTB_ENTRIES];
   logic [XLEN-3:0]        target_mem [BTB_ENTRIES];

   logic [IDX-1:0]   lookup_idx;
   logic [TAG_W-1:0] lookup_tag;
   logic [IDX-1:0]   update_idx;
   logic [TAG_W-1:0] update_tag;
   logic             unused_low_bits;

   assign lookup_idx = lookup_pc[IDX+1:2];
   assign lookup_tag = lookup_pc[XLEN-1:IDX+2];
   assign update_idx = update_pc[IDX+1:2];
   assign update_tag = update_pc[XLEN-1:IDX+2];

   // Word addresses only: the low two bits of every PC/target are implicitly zero.
   assign unused_low_bits = ^{lookup_pc[1:0], update_pc[1:0], update_target[1:0]};

   // Reads see the registered contents, so a same-cycle update shows up next cycle.
   assign hit    = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
   assign target = {target_mem[lookup_idx], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (update_valid) begin
         if (update_taken) begin
            valid[update_idx] <= 1'b1;
         end else if (tag_mem[update_idx] == update_tag) begin
            valid[update_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && update_valid && update_taken) begin
         tag_mem[update_idx]    <= update_tag;
         target_mem[update_idx] <= update_target[XLEN-1:2];
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: PC register, start delay, redirect
// priority, misalignment reporting and BTB-driven next-PC prediction.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int              BTB_ENTRIES  = 16,
   parameter bit              BTB_EN       = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_ready,
   input  logic            ex_redirect,
   input  logic [XLEN-1:0] ex_target,
   input  logic            trap_redirect,
   input  logic [XLEN-1:0] trap_target,
   input  logic            ex_update_valid,
   input  logic [XLEN-1:0] ex_update_pc,
   input  logic            ex_update_taken,
   input  logic [XLEN-1:0] ex_update_target,
   output logic            fetch_valid,
   output logic [XLEN-1:0] fetch_pc,
   output logic            fetch_pred_taken,
   output logic [XLEN-1:0] fetch_pred_target,
   output logic            misalign_err
);

   pc_next_sel_e    next_sel;
   logic [XLEN-1:0] next_pc;
   logic            next_misalign;
   logic            btb_hit;
   logic [XLEN-1:0] btb_target;

   pc_btb #(
      .XLEN        (XLEN),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk           (clk),
      .rst           (rst),
      .lookup_pc     (fetch_pc),
      .hit           (btb_hit),
      .target        (btb_target),
      .update_valid  (ex_update_valid && BTB_EN),
      .update_pc     (ex_update_pc),
      .update_taken  (ex_update_taken),
      .update_target (ex_update_target)
   );

   assign fetch_pred_taken  = btb_hit && BTB_EN;
   assign fetch_pred_target = fetch_pred_taken ? btb_target
                                                : fetch_pc + XLEN'(INST_BYTES);

   // Redirects win even while IF is stalled; the pending request is dropped.
   always_comb begin
      next_sel      = HOLD;
      next_pc       = fetch_pc;
      next_misalign = 1'b0;
      if (trap_redirect) begin
         next_sel = TRAP;
      end else if (ex_redirect) begin
         next_sel = EX;
      end else if (fetch_valid && fetch_ready) begin
         next_sel = PRED;
      end
      case (next_sel)
         TRAP: begin
            next_pc       = {trap_target[XLEN-1:2], 2'b00};
            next_misalign = |trap_target[1:0];
         end
         EX: begin
            next_pc       = {ex_target[XLEN-1:2], 2'b00};
            next_misalign = |ex_target[1:0];
         end
         PRED:    next_pc = fetch_pred_target;
         default: next_pc = fetch_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc     <= RESET_VECTOR;
         fetch_valid  <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         fetch_pc     <= next_pc;
         fetch_valid  <= 1'b1;
         misalign_err <= next_misalign;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run
// against a behavioural model of the fetch PC and BTB.
module tb_pc_gen;

   localparam logic [31:0] RV = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_ready;
   logic        ex_redirect;
   logic [31:0] ex_target;
   logic        trap_redirect;
   logic [31:0] trap_target;
   logic        ex_update_valid;
   logic [31:0] ex_update_pc;
   logic        ex_update_taken;
   logic [31:0] ex_update_target;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        fetch_pred_taken;
   logic [31:0] fetch_pred_target;
   logic        misalign_err;

   int checks = 0;
   int passed = 0;

   // Model: the BTB is kept as "which aligned PC trained slot i, and its target".
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_mis;
   bit          m_bv   [16];
   logic [31:0] m_bpc  [16];
   logic [31:0] m_btgt [16];

   always #5 clk = ~clk;

   pc_gen dut (
      .clk               (clk),
      .rst               (rst),
      .fetch_ready       (fetch_ready),
      .ex_redirect       (ex_redirect),
      .ex_target         (ex_target),
      .trap_redirect     (trap_redirect),
      .trap_target       (trap_target),
      .ex_update_valid   (ex_update_valid),
      .ex_update_pc      (ex_update_pc),
      .ex_update_taken   (ex_update_taken),
      .ex_update_target  (ex_update_target),
      .fetch_valid       (fetch_valid),
      .fetch_pc          (fetch_pc),
      .fetch_pred_taken  (fetch_pred_taken),
      .fetch_pred_target (fetch_pred_target),
      .misalign_err      (misalign_err)
   );

   function automatic logic m_hit();
      return m_bv[m_pc[5:2]] && (m_bpc[m_pc[5:2]] == m_pc);
   endfunction

   function automatic logic [31:0] m_pred();
      return m_hit() ? m_btgt[m_pc[5:2]] : m_pc + 32'd4;
   endfunction

   task automatic model_step();
      logic [31:0] npc;
      logic        nmis;
      int          i;
      if (rst) begin
         m_pc    = RV;
         m_valid = 1'b0;
         m_mis   = 1'b0;
         for (int k = 0; k < 16; k++) m_bv[k] = 1'b0;
         return;
      end
      nmis = 1'b0;
      if (trap_redirect) begin
         npc  = trap_target & ~32'h3;
         nmis = (trap_target % 4) != 0;
      end else if (ex_redirect) begin
         npc  = ex_target & ~32'h3;
         nmis = (ex_target % 4) != 0;
      end else if (m_valid && fetch_ready) begin
         npc = m_pred();
      end else begin
         npc = m_pc;
      end
      if (ex_update_valid) begin
         i = int'((ex_update_pc / 4) % 16);
         if (ex_update_taken) begin
            m_bv[i]   = 1'b1;
            m_bpc[i]  = ex_update_pc & ~32'h3;
            m_btgt[i] = ex_update_target & ~32'h3;
         end else if ((m_bpc[i] / 4) == (ex_update_pc / 4)) begin
            m_bv[i] = 1'b0;
         end
      end
      m_pc    = npc;
      m_valid = 1'b1;
      m_mis   = nmis;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ready);
      fetch_ready      = ready;
      ex_redirect      = 1'b0;
      ex_target        = '0;
      trap_redirect    = 1'b0;
      trap_target      = '0;
      ex_update_valid  = 1'b0;
      ex_update_pc     = '0;
      ex_update_taken  = 1'b0;
      ex_update_target = '0;
   endtask

   task automatic ex_jump(input logic [31:0] tgt);
      ex_redirect = 1'b1;
      ex_target   = tgt;
   endtask

   task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      ex_update_valid  = 1'b1;
      ex_update_pc     = pc;
      ex_update_taken  = taken;
      ex_update_target = tgt;
   endtask

   task automatic test_reset();
      logic [31:0] exp_seq [4];
      exp_seq = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
      idle(1'b1);
      rst = 1'b1;
      tick();
      tick();
      checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", fetch_valid); else passed++;
      checks++; if (fetch_pc !== RV) $display("FAIL reset_pc: got %h want %h", fetch_pc, RV); else passed++;
      checks++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign: got %b want 0", misalign_err); else passed++;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (fetch_valid !== (c != 0)) $display("FAIL start_valid c%0d: got %b want %b", c, fetch_valid, c != 0);
         else passed++;
         checks++;
         if (fetch_pc !== exp_seq[c]) $display("FAIL start_pc c%0d: got %h want %h", c, fetch_pc, exp_seq[c]);
         else passed++;
         tick();
      end
   endtask

   task automatic test_backpressure();
      idle(1'b0);
      ex_jump(32'h8000_0010);
      tick();
      idle(1'b0);
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (fetch_pc !== 32'h8000_0010) $display("FAIL hold_pc c%0d: got %h want 80000010", c, fetch_pc);
         else passed++;
         checks++;
         if (fetch_pred_target !== 32'h8000_0014 || fetch_pred_taken !== 1'b0)
            $display("FAIL hold_pred c%0d: got %b/%h want 0/80000014", c, fetch_pred_taken, fetch_pred_target);
         else passed++;
      end
      fetch_ready = 1'b1;
      tick();
      checks++; if (fetch_pc !== 32'h8000_0014) $display("FAIL release_pc: got %h want 80000014", fetch_pc); else passed++;
   endtask

   task automatic test_redirect();
      idle(1'b0);
      ex_jump(32'h8000_0102);
      tick();
      idle(1'b0);
      checks++; if (fetch_pc !== 32'h8000_0100) $display("FAIL ex_redir_pc: got %h want 80000100", fetch_pc); else passed++;
      checks++; if (misalign_err !== 1'b1) $display("FAIL misalign_pulse: got %b want 1", misalign_err); else passed++;
      tick();
      checks++; if (misalign_err !== 1'b0) $display("FAIL misalign_clear: got %b want 0", misalign_err); else passed++;
      trap_redirect = 1'b1;
      trap_target   = 32'h8000_0200;
      ex_jump(32'h8000_0303);
      tick();
      idle(1'b0);
      checks++; if (fetch_pc !== 32'h8000_0200) $display("FAIL trap_prio_pc: got %h want 80000200", fetch_pc); else passed++;
      checks++; if (misalign_err !== 1'b0) $display("FAIL trap_only_checked: got %b want 0", misalign_err); else passed++;
   endtask

   task automatic test_btb();
      idle(1'b0);
      ex_jump(32'h8000_0020);
      train(32'h8000_0020, 1'b1, 32'h8000_0080);
      tick();
      idle(1'b0);
      checks++;
      if (fetch_pred_taken !== 1'b1 || fetch_pred_target !== 32'h8000_0080)
         $display("FAIL btb_hit: got %b/%h want 1/80000080", fetch_pred_taken, fetch_pred_target);
      else passed++;
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      checks++; if (fetch_pc !== 32'h8000_0080) $display("FAIL btb_follow: got %h want 80000080", fetch_pc); else passed++;
      ex_jump(32'h8000_0020);
      train(32'h8000_0020, 1'b0, 32'h0);
      tick();
      idle(1'b1);
      checks++; if (fetch_pred_taken !== 1'b0) $display("FAIL btb_untrain: got %b want 0", fetch_pred_taken); else passed++;
      tick();
      fetch_ready = 1'b0;
      checks++; if (fetch_pc !== 32'h8000_0024) $display("FAIL btb_seq_after_untrain: got %h want 80000024", fetch_pc); else passed++;
   endtask

   task automatic test_alias_same_cycle();
      idle(1'b0);
      ex_jump(32'h8000_0060);
      train(32'h8000_0020, 1'b1, 32'h8000_0080);
      tick();
      idle(1'b0);
      checks++;
      if (fetch_pred_taken !== 1'b0 || fetch_pred_target !== 32'h8000_0064)
         $display("FAIL alias_nohit: got %b/%h want 0/80000064", fetch_pred_taken, fetch_pred_target);
      else passed++;
      ex_jump(32'h8000_0020);
      tick();
      idle(1'b1);
      train(32'h8000_0020, 1'b0, 32'h0);
      checks++;
      if (fetch_pred_taken !== 1'b1 || fetch_pred_target !== 32'h8000_0080)
         $display("FAIL same_cycle_old: got %b/%h want 1/80000080", fetch_pred_taken, fetch_pred_target);
      else passed++;
      tick();
      idle(1'b0);
      checks++; if (fetch_pc !== 32'h8000_0080) $display("FAIL same_cycle_follow: got %h want 80000080", fetch_pc); else passed++;
      ex_jump(32'h8000_0020);
      tick();
      idle(1'b0);
      checks++; if (fetch_pred_taken !== 1'b0) $display("FAIL same_cycle_new: got %b want 0", fetch_pred_taken); else passed++;
   endtask

   task automatic test_wrap_reset();
      idle(1'b0);
      trap_redirect = 1'b1;
      trap_target   = 32'hFFFF_FFFC;
      train(32'h8000_0000, 1'b1, 32'h8000_0040);
      tick();
      idle(1'b1);
      checks++; if (fetch_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_redir: got %h want fffffffc", fetch_pc); else passed++;
      tick();
      checks++; if (fetch_pc !== 32'h0000_0000) $display("FAIL wrap_pc: got %h want 00000000", fetch_pc); else passed++;
      rst = 1'b1;
      ex_jump(32'h1234_5679);
      trap_redirect = 1'b1;
      trap_target   = 32'h0000_1002;
      train(32'h8000_0000, 1'b1, 32'h8000_0040);
      tick();
      rst = 1'b0;
      idle(1'b0);
      checks++; if (fetch_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", fetch_valid); else passed++;
      checks++; if (fetch_pc !== RV) $display("FAIL midrst_pc: got %h want %h", fetch_pc, RV); else passed++;
      checks++; if (misalign_err !== 1'b0) $display("FAIL midrst_misalign: got %b want 0", misalign_err); else passed++;
      checks++; if (fetch_pred_taken !== 1'b0) $display("FAIL midrst_btb_empty: got %b want 0", fetch_pred_taken); else passed++;
      tick();
      checks++; if (fetch_valid !== 1'b1) $display("FAIL midrst_restart: got %b want 1", fetch_valid); else passed++;
   endtask

   function automatic logic [31:0] rand_addr(input bit allow_misalign);
      logic [31:0] a;
      a = RV + 32'($urandom_range(0, 31)) * 32'd4;
      if (allow_misalign && $urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      return a;
   endfunction

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         idle($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 15) == 0) begin
            trap_redirect = 1'b1;
            trap_target   = rand_addr(1'b1);
         end
         if ($urandom_range(0, 7) == 0) ex_jump(rand_addr(1'b1));
         if ($urandom_range(0, 3) == 0) train(rand_addr(1'b0), $urandom_range(0, 1) == 1, rand_addr(1'b1));
         checks++; if (fetch_valid !== m_valid) $display("FAIL rnd_valid c%0d: got %b want %b", c, fetch_valid, m_valid); else passed++;
         checks++; if (fetch_pc !== m_pc) $display("FAIL rnd_pc c%0d: got %h want %h", c, fetch_pc, m_pc); else passed++;
         checks++; if (misalign_err !== m_mis) $display("FAIL rnd_misalign c%0d: got %b want %b", c, misalign_err, m_mis); else passed++;
         checks++; if (fetch_pred_taken !== m_hit()) $display("FAIL rnd_pred_taken c%0d: got %b want %b", c, fetch_pred_taken, m_hit()); else passed++;
         checks++; if (fetch_pred_target !== m_pred()) $display("FAIL rnd_pred_target c%0d: got %h want %h", c, fetch_pred_target, m_pred()); else passed++;
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 16; k++) begin
         m_bv[k]   = 1'b0;
         m_bpc[k]  = '0;
         m_btgt[k] = '0;
      end
      m_pc    = RV;
      m_valid = 1'b0;
      m_mis   = 1'b0;
      rst     = 1'b1;
      idle(1'b0);
      test_reset();
      test_backpressure();
      test_redirect();
      test_btb();
      test_alias_same_cycle();
      test_wrap_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
